// File: rtl/long_divider.sv
// rtl/long_divider.sv - sequential unsigned restoring divider, one quotient bit per clock.
// Optional DIV_BY_ZERO_FLAG_EN adds a DivByZero flag and a one-cycle zero-divisor shortcut.
module long_divider #(
  parameter int N = 8
) (
  input  logic         Clock,
  input  logic         Resetn,
  input  logic         s,
  input  logic         LA,
  input  logic         EB,
  input  logic [N-1:0] DataA,
  input  logic [N-1:0] DataB,
  output logic [N-1:0] R,
  output logic [N-1:0] Q,
`ifdef DIV_BY_ZERO_FLAG_EN
  output logic         DivByZero,
`endif
  output logic         Done
);

  localparam int CW = (N > 2) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state;
  state_t         state_next;
  logic [N-1:0]   a;
  logic [N-1:0]   b;
  logic [N-1:0]   r;
  logic [CW-1:0]  cnt;
  logic [N:0]     p;
  logic [N:0]     diff;
  logic           ge;
  logic [N-1:0]   a_eff;
  logic [N-1:0]   b_eff;
  logic           zero_div;

  // Operand values as they will be after this edge's loads; the start cycle uses them.
  assign a_eff = LA ? DataA : a;
  assign b_eff = EB ? DataB : b;

`ifdef DIV_BY_ZERO_FLAG_EN
  assign zero_div = (b_eff == '0);
`else
  assign zero_div = 1'b0;
`endif

  assign p    = {r, a[N-1]};
  assign diff = p - {1'b0, b};
  assign ge   = (p >= {1'b0, b});

  always_ff @(posedge Clock or posedge Resetn) begin
    if (Resetn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (s) begin
          state_next = zero_div ? DONE : BUSY;
        end
      end
      BUSY: begin
        if (cnt == '0) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (!s) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge Resetn) begin
    if (Resetn) begin
      a   <= '0;
      b   <= '0;
      r   <= '0;
      cnt <= '0;
`ifdef DIV_BY_ZERO_FLAG_EN
      DivByZero <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (LA) begin
            a <= DataA;
          end
          if (EB) begin
            b <= DataB;
          end
          if (s) begin
            r   <= '0;
            cnt <= CW'(N - 1);
`ifdef DIV_BY_ZERO_FLAG_EN
            DivByZero <= zero_div;
            // Shortcut produces the same Q/R the full iteration would give for B=0.
            if (zero_div) begin
              a <= '1;
              r <= a_eff;
            end
`endif
          end
        end
        BUSY: begin
          r   <= ge ? diff[N-1:0] : p[N-1:0];
          a   <= {a[N-2:0], ge};
          cnt <= cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign Q    = a;
  assign R    = r;
  assign Done = (state == DONE);

endmodule

// File: tb/tb_long_divider.sv
// tb/tb_long_divider.sv - randomized self-checking bench for long_divider against an arithmetic model.
module tb_long_divider;

  localparam int N = 8;

  logic         Clock;
  logic         Resetn;
  logic         s;
  logic         LA;
  logic         EB;
  logic [N-1:0] DataA;
  logic [N-1:0] DataB;
  logic [N-1:0] R;
  logic [N-1:0] Q;
  logic         Done;
`ifdef DIV_BY_ZERO_FLAG_EN
  logic         DivByZero;
`endif

  int checks = 0;
  int errors = 0;

  long_divider #(.N(N)) dut (
    .Clock    (Clock),
    .Resetn   (Resetn),
    .s        (s),
    .LA       (LA),
    .EB       (EB),
    .DataA    (DataA),
    .DataB    (DataB),
    .R        (R),
    .Q        (Q),
`ifdef DIV_BY_ZERO_FLAG_EN
    .DivByZero(DivByZero),
`endif
    .Done     (Done)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Full division transaction; noise scribbles on LA/EB/Data while the divider runs.
  task automatic do_div(input int av, input int bv, input bit noise);
    int exp_q, exp_r, exp_lat, edges;
    if (bv == 0) begin
      exp_q = (1 << N) - 1;
      exp_r = av;
    end else begin
      exp_q = av / bv;
      exp_r = av % bv;
    end
    exp_lat = N + 1;
`ifdef DIV_BY_ZERO_FLAG_EN
    if (bv == 0) exp_lat = 1;
`endif
    DataA = N'(av);
    DataB = N'(bv);
    LA = 1'b1;
    EB = 1'b1;
    s  = 1'b1;
    edges = 0;
    while (!Done && edges < 40) begin
      @(negedge Clock);
      edges++;
      if (noise) begin
        LA = 1'($urandom);
        EB = 1'($urandom);
        DataA = N'($urandom);
        DataB = N'($urandom);
      end else begin
        LA = 1'b0;
        EB = 1'b0;
      end
    end
    LA = 1'b0;
    EB = 1'b0;
    check($sformatf("latency %0d/%0d", av, bv), edges, exp_lat);
    check($sformatf("Q %0d/%0d", av, bv), Q, exp_q);
    check($sformatf("R %0d/%0d", av, bv), R, exp_r);
`ifdef DIV_BY_ZERO_FLAG_EN
    check($sformatf("DivByZero %0d/%0d", av, bv), DivByZero, (bv == 0));
`endif
    @(negedge Clock);
    check("done held", Done, 1'b1);
    check("Q held", Q, exp_q);
    s = 1'b0;
    @(negedge Clock);
    check("done fall", Done, 1'b0);
    check("Q kept in idle", Q, exp_q);
    check("R kept in idle", R, exp_r);
  endtask

  initial begin
    Resetn = 1'b1;
    s = 1'b0;
    LA = 1'b0;
    EB = 1'b0;
    DataA = '0;
    DataB = '0;
    repeat (2) @(negedge Clock);
    check("reset Q", Q, 0);
    check("reset R", R, 0);
    check("reset Done", Done, 0);
    Resetn = 1'b0;
    @(negedge Clock);

    do_div(16, 2, 1'b0);
    do_div(200, 7, 1'b0);
    do_div(5, 9, 1'b0);
    do_div(255, 1, 1'b0);
    do_div(255, 255, 1'b0);
    do_div(100, 0, 1'b0);
    do_div(200, 7, 1'b1);

    // Reset in the middle of a division.
    DataA = 8'd16;
    DataB = 8'd2;
    LA = 1'b1;
    EB = 1'b1;
    s = 1'b1;
    @(negedge Clock);
    LA = 1'b0;
    EB = 1'b0;
    repeat (3) @(negedge Clock);
    Resetn = 1'b1;
    #1;
    check("midreset Q", Q, 0);
    check("midreset R", R, 0);
    check("midreset Done", Done, 0);
    s = 1'b0;
    @(negedge Clock);
    Resetn = 1'b0;
    @(negedge Clock);
    do_div(16, 2, 1'b0);

    for (int i = 0; i < 40; i++) begin
      int av, bv;
      av = int'($urandom_range(0, (1 << N) - 1));
      bv = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, (1 << N) - 1));
      do_div(av, bv, ($urandom_range(0, 2) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/long_divider.md
Name: long_divider

Overview:
- Sequential unsigned restoring divider: Q = DataA / DataB, R = DataA mod DataB.
- Computes one quotient bit per clock.
- Operands are loaded into internal registers under LA/EB strobes; a start/acknowledge handshake on s/Done controls each division.
- Arithmetic datapath block used by controller logic that owns the operand buses.

Parameters:
- N, 8, operand/result width in bits (N >= 2).

Ports:
- Clock  in  1  system clock; all state updates on rising edge.
- Resetn  in  1  asynchronous reset, active-high; the port keeps the codebase name Resetn, but polarity is high.
- s  in  1  start; level-sensitive, held high by the requester until Done is seen.
- LA  in  1  load dividend register from DataA.
- EB  in  1  load divisor register from DataB.
- DataA  in  N  dividend.
- DataB  in  N  divisor.
- R  out  N  remainder register.
- Q  out  N  quotient register (shares storage with the dividend register).
- Done  out  1  result valid; decoded from the DONE state.

Behaviour:
- Reset (asynchronous, Resetn=1): state IDLE; A, B, R, counter all 0; Q=0, R=0, Done=0.
- States:
  - IDLE: LA=1 loads A<=DataA; EB=1 loads B<=DataB; both may be set in the same cycle. s=1 moves to BUSY, clears R and sets counter to N-1. LA/EB in the start cycle still load, so the new values are used.
  - BUSY: one iteration per cycle.
    - P = {R, A[N-1]} (N+1 bits).
    - If P >= {0,B}: R <= P-B and quotient bit q=1; else R <= P[N-1:0], q=0.
    - A <= {A[N-2:0], q}.
    - Counter decrements; when the counter is 0 at the edge, go to DONE.
  - DONE: Done=1; A (=Q) and R frozen. s=1 stays in DONE; s=0 returns to IDLE, and Done falls.
- Latency: start edge, then N BUSY edges. Done is high after N+1 rising edges from the edge that sampled s=1 in IDLE; for N=8, 9 cycles.
- LA and EB are ignored outside IDLE. Operands cannot change mid-division.
- Q and R show intermediate values during BUSY. They are valid only while Done=1 and remain valid in IDLE until the next start or load.
- Divide by zero (B=0): no special case. The algorithm yields Q = all ones and R = A (e.g. 100/0 -> Q=FF, R=64). Done timing is unchanged.
- Reset asserted mid-operation aborts immediately to reset values. Operation restarts only from IDLE with a fresh s.
- s held high after returning from DONE to IDLE is impossible, because leaving DONE requires s=0. The next division needs s to rise again.
- All arithmetic is unsigned. The N+1-bit compare/subtract guarantees R < B whenever B != 0.

Optional Feature:
- Macro DIV_BY_ZERO_FLAG_EN.
- Defined:
  - Adds output DivByZero (1 bit). It is registered: set on the start edge when B==0, cleared on start when B!=0, cleared by reset.
  - When B==0, the block skips BUSY and goes straight from IDLE to DONE the next cycle, with Q = all ones and R = A. This matches the undefined-case values.
- Not defined: no DivByZero port; a zero divisor runs the normal N-iteration sequence.

Test Plan:
- Reset; LA/EB with A=0x10, B=0x02; pulse s high and hold -> Done after 9 edges; Q=0x08, R=0x00; Done stays high while s=1 and drops one cycle after s=0.
- A=200, B=7 -> Q=28 (0x1C), R=4.
- A=5, B=9 (divisor > dividend) -> Q=0, R=5; A=255, B=1 -> Q=255, R=0; A=255, B=255 -> Q=1, R=0.
- A=100, B=0 -> Q=0xFF, R=0x64.
  - Without the macro: Done after 9 edges.
  - With DIV_BY_ZERO_FLAG_EN: Done after 1 edge and DivByZero=1.
- Assert Resetn for one cycle during BUSY -> Q, R, Done go to 0 immediately. A following full load/start sequence with 16/2 gives Q=8, R=0.
- Toggle LA/EB with new data during BUSY -> no effect on the result. Back-to-back divisions (s low one cycle, then high) both give correct results.
